// File: rtl/product_accumulator_v_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : product_accumulator_v_if
//  Purpose  : Product-in / result-out handshake bundle for the product
//             accumulator. The slave modport is the accumulator side; the
//             master modport is the producer/consumer side.
//  Revision : 1.0 - initial release
// ============================================================================
interface product_accumulator_v_if #(
  parameter int ACC_W = 12
);
  logic             i_clear;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [3:0]       i_fu0;
  logic [3:0]       i_fu1;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [ACC_W-1:0] o_sum;
  logic             o_ovf;
  logic [4:0]       o_cnt;

  modport slave (
    input  i_clear, i_in_valid, i_fu0, i_fu1, i_out_ready,
    output o_in_ready, o_out_valid, o_sum, o_ovf, o_cnt
  );

  modport master (
    output i_clear, i_in_valid, i_fu0, i_fu1, i_out_ready,
    input  o_in_ready, o_out_valid, o_sum, o_ovf, o_cnt
  );
endinterface
`default_nettype wire

// File: rtl/product_accumulator_v.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : product_accumulator_v
//  Purpose  : Sums LEN consecutive 8-bit products ({fu1, fu0}) into a
//             saturating ACC_W-bit result with a sticky overflow flag, under
//             valid/ready handshakes on both the input and the result side.
//  Revision : 1.0 - initial release
// ============================================================================
module product_accumulator_v #(
  parameter int ACC_W = 12,   // 8..16
  parameter int LEN   = 4     // 1..16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  product_accumulator_v_if.slave  bus_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [4:0] c_len = 5'(LEN);

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [4:0]       cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [ACC_W-1:0] acc_d;
  logic [4:0]       cnt_d;
  logic             ovf_d;
  logic [ACC_W:0]   w_prod;
  logic [ACC_W:0]   w_sum;
  logic             w_accept;
  logic             w_last;

  // Product zero-extended one bit beyond the accumulator so the carry out
  // of the add is the saturation indicator.
  assign w_prod   = {{(ACC_W-7){1'b0}}, bus_if.i_fu1, bus_if.i_fu0};
  assign w_sum    = {1'b0, acc_q} + w_prod;
  assign w_accept = bus_if.i_in_valid & in_ready_q;

  // Next accumulator/count/overflow for an accepted product: the first
  // product of a result loads, later ones add with saturation.
  always_comb begin
    cnt_d = cnt_q + 5'd1;
    if (state_q == S_IDLE) begin
      acc_d = w_prod[ACC_W-1:0];
      ovf_d = 1'b0;
    end else if (w_sum[ACC_W]) begin
      acc_d = '1;
      ovf_d = 1'b1;
    end else begin
      acc_d = w_sum[ACC_W-1:0];
      ovf_d = ovf_q;
    end
  end

  // cnt_q is zero in IDLE, so cnt_d is 1 there and LEN==1 completes at once.
  assign w_last = (cnt_d == c_len);

  // Control FSM with registered handshake outputs; clear beats everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (bus_if.i_clear) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACC: begin
          if (w_accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (w_last) begin
              state_q     <= S_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= S_ACC;
            end
          end
        end
        S_HOLD: begin
          if (bus_if.i_out_ready) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.o_in_ready  = in_ready_q;
  assign bus_if.o_out_valid = out_valid_q;
  assign bus_if.o_sum       = acc_q;
  assign bus_if.o_ovf       = ovf_q;
  assign bus_if.o_cnt       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator_v.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_product_accumulator_v
//  Purpose  : Self-checking bench for product_accumulator_v. Three builds are
//             instantiated (12/4, 9/4, 12/1); sel routes stimulus to one and
//             its outputs to the observation signals.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_product_accumulator_v;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] sel       = 2'd0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear     = 1'b0;
  logic [7:0] prod      = 8'h00;

  int checks   = 0;
  int failures = 0;
  string phase = "reset";

  typedef struct {
    logic [15:0] sum;
    logic        ovf;
    logic [4:0]  cnt;
  } exp_t;
  exp_t sb[$];

  product_accumulator_v_if #(.ACC_W(12)) if0 ();
  product_accumulator_v_if #(.ACC_W(9))  if1 ();
  product_accumulator_v_if #(.ACC_W(12)) if2 ();

  product_accumulator_v #(.ACC_W(12), .LEN(4)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus_if(if0));
  product_accumulator_v #(.ACC_W(9),  .LEN(4)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus_if(if1));
  product_accumulator_v #(.ACC_W(12), .LEN(1)) u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus_if(if2));

  assign if0.i_in_valid  = in_valid  && (sel == 2'd0);
  assign if0.i_out_ready = out_ready && (sel == 2'd0);
  assign if0.i_clear     = clear     && (sel == 2'd0);
  assign if0.i_fu0       = prod[3:0];
  assign if0.i_fu1       = prod[7:4];
  assign if1.i_in_valid  = in_valid  && (sel == 2'd1);
  assign if1.i_out_ready = out_ready && (sel == 2'd1);
  assign if1.i_clear     = clear     && (sel == 2'd1);
  assign if1.i_fu0       = prod[3:0];
  assign if1.i_fu1       = prod[7:4];
  assign if2.i_in_valid  = in_valid  && (sel == 2'd2);
  assign if2.i_out_ready = out_ready && (sel == 2'd2);
  assign if2.i_clear     = clear     && (sel == 2'd2);
  assign if2.i_fu0       = prod[3:0];
  assign if2.i_fu1       = prod[7:4];

  logic        obs_valid, obs_ready, obs_ovf;
  logic [15:0] obs_sum;
  logic [4:0]  obs_cnt;

  always_comb begin
    obs_valid = if0.o_out_valid;
    obs_ready = if0.o_in_ready;
    obs_ovf   = if0.o_ovf;
    obs_sum   = 16'(if0.o_sum);
    obs_cnt   = if0.o_cnt;
    case (sel)
      2'd1: begin
        obs_valid = if1.o_out_valid;
        obs_ready = if1.o_in_ready;
        obs_ovf   = if1.o_ovf;
        obs_sum   = 16'(if1.o_sum);
        obs_cnt   = if1.o_cnt;
      end
      2'd2: begin
        obs_valid = if2.o_out_valid;
        obs_ready = if2.o_in_ready;
        obs_ovf   = if2.o_ovf;
        obs_sum   = 16'(if2.o_sum);
        obs_cnt   = if2.o_cnt;
      end
      default: ;
    endcase
  end

  // Reference model of the partial result in progress.
  int unsigned m_acc = 0;
  int unsigned m_cnt = 0;
  logic        m_ovf = 1'b0;

  function automatic int unsigned cur_accw();
    return (sel == 2'd1) ? 9 : 12;
  endfunction

  function automatic int unsigned cur_len();
    return (sel == 2'd2) ? 1 : 4;
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
      $error("check %s/%s", phase, tag);
    end
  endtask

  // Present one product for one cycle (called at a negedge, returns at the
  // following negedge) and update the model as the DUT should.
  task automatic send(input logic [7:0] p);
    int unsigned s;
    int unsigned mx;
    chk("in_ready_before", 32'(obs_ready), 32'd1);
    in_valid = 1'b1;
    prod     = p;
    mx = (32'd1 << cur_accw()) - 1;
    if (m_cnt == 0) begin
      m_acc = p;
      m_ovf = 1'b0;
    end else begin
      s = m_acc + p;
      if (s > mx) begin
        m_acc = mx;
        m_ovf = 1'b1;
      end else begin
        m_acc = s;
      end
    end
    m_cnt++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("cnt", 32'(obs_cnt), m_cnt);
    chk("sum", 32'(obs_sum), m_acc);
    chk("ovf", 32'(obs_ovf), 32'(m_ovf));
    if (m_cnt == cur_len()) begin
      sb.push_back('{sum: 16'(m_acc), ovf: m_ovf, cnt: 5'(m_cnt)});
      model_reset();
    end
  endtask

  // Expect a result to be presented now (one cycle after the last accept),
  // compare against the scoreboard, then take it.
  task automatic collect();
    exp_t e;
    chk("out_valid", 32'(obs_valid), 32'd1);
    chk("in_ready_hold", 32'(obs_ready), 32'd0);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s/scoreboard observed=empty expected=entry", phase);
    end else begin
      e = sb.pop_front();
      chk("res_sum", 32'(obs_sum), 32'(e.sum));
      chk("res_ovf", 32'(obs_ovf), 32'(e.ovf));
      chk("res_cnt", 32'(obs_cnt), 32'(e.cnt));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after", 32'(obs_valid), 32'd0);
    chk("cnt_after", 32'(obs_cnt), 32'd0);
    chk("sum_after", 32'(obs_sum), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [4];
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sum", 32'(obs_sum), 32'd0);
    chk("rst_ovf", 32'(obs_ovf), 32'd0);
    chk("rst_cnt", 32'(obs_cnt), 32'd0);
    chk("rst_valid", 32'(obs_valid), 32'd0);
    chk("rst_ready", 32'(obs_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back 4 x 0xE1 = 900
    phase = "b2b";
    repeat (4) send(8'hE1);
    collect();

    // Bubbles of 0..3 cycles; state must hold across them
    phase = "bubbles";
    vals = '{8'h10, 8'h01, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) begin
      send(vals[i]);
      if (i < 3) begin
        for (int b = 0; b < i + 1; b++) begin
          @(negedge clk);
          chk("bubble_cnt", 32'(obs_cnt), m_cnt);
          chk("bubble_sum", 32'(obs_sum), m_acc);
        end
      end
    end
    collect();

    // Backpressure: result held, in_valid ignored
    phase = "backpressure";
    repeat (4) send(8'h02);
    in_valid = 1'b1;
    prod     = 8'h55;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(obs_valid), 32'd1);
      chk("bp_sum", 32'(obs_sum), 32'd8);
      chk("bp_ovf", 32'(obs_ovf), 32'd0);
      chk("bp_ready", 32'(obs_ready), 32'd0);
      chk("bp_cnt", 32'(obs_cnt), 32'd4);
    end
    collect();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_absorb", 32'(obs_cnt), 32'd0);
    repeat (4) send(8'h01);
    collect();

    // Clear mid-result, coincident with a valid product
    phase = "clear";
    send(8'h20);
    send(8'h20);
    in_valid = 1'b1;
    prod     = 8'h20;
    clear    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    chk("clr_cnt", 32'(obs_cnt), 32'd0);
    chk("clr_sum", 32'(obs_sum), 32'd0);
    chk("clr_valid", 32'(obs_valid), 32'd0);
    repeat (4) send(8'h01);
    collect();

    // Saturation on the 9-bit build
    phase = "saturate";
    sel = 2'd1;
    @(negedge clk);
    repeat (4) send(8'hE1);
    collect();
    repeat (4) send(8'h01);
    collect();

    // LEN=1 build
    phase = "len1";
    sel = 2'd2;
    @(negedge clk);
    send(8'hFF);
    collect();

    // Asynchronous reset mid-result
    phase = "async_rst";
    sel = 2'd0;
    @(negedge clk);
    send(8'h10);
    send(8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sum", 32'(obs_sum), 32'd0);
    chk("ar_cnt", 32'(obs_cnt), 32'd0);
    chk("ar_valid", 32'(obs_valid), 32'd0);
    chk("ar_ready", 32'(obs_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (4) send(8'h03);
    collect();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
